// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control-token and TERC4 code tables plus shared types
// for the channel decoder.
package tmds_pkg;
  typedef logic [9:0] tmds_sym_t;
  typedef enum logic {SEARCH, LOCKED} align_state_t;
  localparam tmds_sym_t CTRL_TOKEN [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  localparam tmds_sym_t TERC4_TABLE [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
  };
endpackage

// File: rtl/tmds_bitslip_aligner.sv
// tmds_bitslip_aligner: selects a 10b symbol out of two raw words at the current
// slip offset, hunts for recurring control tokens and tracks lock.
module tmds_bitslip_aligner
  import tmds_pkg::*;
#(
  parameter int CTRL_LOCK_COUNT = 8,
  parameter int SEARCH_TIMEOUT  = 2048,
  parameter int LOCK_TIMEOUT    = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_raw_i,
  input  logic       tok_i,
  output logic [9:0] aligned_o,
  output logic       locked_o,
  output logic [3:0] slip_offset_o
);
  localparam int RW = $clog2(CTRL_LOCK_COUNT + 1);
  localparam int SW = $clog2(SEARCH_TIMEOUT);
  localparam int GW = $clog2(LOCK_TIMEOUT);
  localparam logic [RW-1:0] R_MAX  = RW'(CTRL_LOCK_COUNT);
  localparam logic [SW-1:0] S_LAST = SW'(SEARCH_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(LOCK_TIMEOUT - 1);
  tmds_sym_t     prev_q, aligned_q, aligned_d;
  align_state_t  state_q, state_d;
  logic [3:0]    slip_q, slip_d;
  logic [RW-1:0] run_q, run_d;
  logic [SW-1:0] search_q, search_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    skip_q, skip_d;
  // Offset 0 selects prev_q exactly; higher offsets pull bits from the newer word.
  assign aligned_d = 10'({tmds_raw_i, prev_q} >> slip_q);
  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    run_d    = run_q;
    search_d = search_q;
    gap_d    = gap_q;
    skip_d   = skip_q;
    if (state_q == SEARCH) begin
      search_d = (search_q == S_LAST) ? search_q : search_q + 1'b1;
      if (skip_q != 2'd0) skip_d = skip_q - 1'b1;
      else run_d = !tok_i ? '0 : (run_q == R_MAX) ? run_q : run_q + 1'b1;
      if (run_d == R_MAX) begin
        state_d = LOCKED;
        gap_d   = '0;
      end else if (search_q == S_LAST) begin
        slip_d   = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
        run_d    = '0;
        search_d = '0;
        skip_d   = 2'd2;
      end
    end else begin
      gap_d = tok_i ? '0 : (gap_q == G_LAST) ? gap_q : gap_q + 1'b1;
      if (!tok_i && gap_q == G_LAST) begin
        state_d  = SEARCH;
        run_d    = '0;
        search_d = '0;
        skip_d   = 2'd0;
      end
    end
  end
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      aligned_q <= '0;
      state_q   <= SEARCH;
      slip_q    <= '0;
      run_q     <= '0;
      search_q  <= '0;
      gap_q     <= '0;
      skip_q    <= '0;
    end else begin
      prev_q    <= tmds_raw_i;
      aligned_q <= aligned_d;
      state_q   <= state_d;
      slip_q    <= slip_d;
      run_q     <= run_d;
      search_q  <= search_d;
      gap_q     <= gap_d;
      skip_q    <= skip_d;
    end
  end
  assign aligned_o     = aligned_q;
  assign locked_o      = (state_q == LOCKED);
  assign slip_offset_o = slip_q;
endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: one TMDS receive channel - bit alignment, control/video decode.
// TERC4 nibble decode is built only when TMDS_DECODER_TERC4_EN is defined.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_LOCK_COUNT = 8,
  parameter int SEARCH_TIMEOUT  = 2048,
  parameter int LOCK_TIMEOUT    = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_raw,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       is_ctrl,
  output logic [3:0] terc4,
  output logic       terc4_valid,
  output logic       locked,
  output logic [3:0] slip_offset
);
  tmds_sym_t  q;
  logic       tok, lk, de_q, de_d, is_ctrl_q, is_ctrl_d;
  logic [1:0] c, ctrl_q, ctrl_d;
  logic [7:0] t, dec, data_q, data_d;
  tmds_bitslip_aligner #(
    .CTRL_LOCK_COUNT(CTRL_LOCK_COUNT),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT)
  ) u_align (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .tmds_raw_i   (tmds_raw),
    .tok_i        (tok),
    .aligned_o    (q),
    .locked_o     (lk),
    .slip_offset_o(slip_offset)
  );
  always_comb begin
    tok = 1'b0;
    c   = 2'd0;
    for (int i = 0; i < 4; i++)
      if (q == CTRL_TOKEN[i]) begin
        tok = 1'b1;
        c   = 2'(i);
      end
  end
  // Undo the transmit XOR/XNOR chain after optional inversion.
  assign t   = q[9] ? ~q[7:0] : q[7:0];
  assign dec = {t[7:1] ^ t[6:0] ^ {7{~q[8]}}, t[0]};
  always_comb begin
    data_d    = tok ? data_q : dec;
    ctrl_d    = tok ? c : ctrl_q;
    de_d      = ~tok & lk;
    is_ctrl_d = tok;
  end
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      ctrl_q    <= '0;
      de_q      <= 1'b0;
      is_ctrl_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      de_q      <= de_d;
      is_ctrl_q <= is_ctrl_d;
    end
  end
  assign data    = data_q;
  assign ctrl    = ctrl_q;
  assign de      = de_q;
  assign is_ctrl = is_ctrl_q;
  assign locked  = lk;
`ifdef TMDS_DECODER_TERC4_EN
  logic [3:0] nib, terc4_q;
  logic       hit, terc4_valid_q;
  always_comb begin
    hit = 1'b0;
    nib = 4'd0;
    for (int i = 0; i < 16; i++)
      if (q == TERC4_TABLE[i]) begin
        hit = 1'b1;
        nib = 4'(i);
      end
  end
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      terc4_q       <= '0;
      terc4_valid_q <= 1'b0;
    end else begin
      terc4_q       <= nib;
      terc4_valid_q <= hit;
    end
  end
  assign terc4       = terc4_q;
  assign terc4_valid = terc4_valid_q;
`else
  assign terc4       = 4'd0;
  assign terc4_valid = 1'b0;
`endif
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: randomized self-checking bench for tmds_channel_decoder
// against a word-level reference model (honours TMDS_DECODER_TERC4_EN).
module tb_tmds_channel_decoder;
  localparam int CLC = 8;
  localparam int ST  = 16;
  localparam int LT  = 64;
  logic       clk_pixel = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] tmds_raw = '0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de, is_ctrl, terc4_valid, locked;
  logic [3:0] terc4, slip_offset;
  int n_run = 0;
  int n_fail = 0;
  logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] terc_tab [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
  };
  logic [9:0] hist [$];
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  bit         mdl_on = 0;
  bit         de_known = 0;
  tmds_channel_decoder #(
    .CTRL_LOCK_COUNT(CLC),
    .SEARCH_TIMEOUT (ST),
    .LOCK_TIMEOUT   (LT)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .tmds_raw   (tmds_raw),
    .data       (data),
    .ctrl       (ctrl),
    .de         (de),
    .is_ctrl    (is_ctrl),
    .terc4      (terc4),
    .terc4_valid(terc4_valid),
    .locked     (locked),
    .slip_offset(slip_offset)
  );
  always #5 clk_pixel = ~clk_pixel;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic check_idle(input string p);
    check({p, "_data"}, data, 0);
    check({p, "_ctrl"}, ctrl, 0);
    check({p, "_de"}, de, 0);
    check({p, "_is_ctrl"}, is_ctrl, 0);
    check({p, "_terc4"}, terc4, 0);
    check({p, "_terc4_valid"}, terc4_valid, 0);
    check({p, "_locked"}, locked, 0);
    check({p, "_slip"}, slip_offset, 0);
  endtask
  function automatic logic [7:0] dec(input logic [9:0] w);
    logic [7:0] t, d;
    t = w[9] ? ~w[7:0] : w[7:0];
    d = t ^ 8'(t << 1);
    if (!w[8]) d = d ^ 8'hFE;
    return d;
  endfunction
  task automatic model_step(input logic [9:0] w);
    bit         is_t, tv;
    logic [1:0] c;
    logic [3:0] tn;
    is_t = 0; tv = 0; c = 0; tn = 0;
    foreach (tok_tab[i]) if (w == tok_tab[i]) begin is_t = 1; c = 2'(i); end
`ifdef TMDS_DECODER_TERC4_EN
    foreach (terc_tab[i]) if (w == terc_tab[i]) begin tv = 1; tn = 4'(i); end
`endif
    if (is_t) m_ctrl = c;
    else m_data = dec(w);
    check("data", data, m_data);
    check("ctrl", ctrl, m_ctrl);
    check("is_ctrl", is_ctrl, is_t);
    check("terc4_valid", terc4_valid, tv);
    check("terc4", terc4, tn);
    if (de_known) begin
      check("de", de, !is_t);
      check("locked", locked, 1);
    end
  endtask
  task automatic drive(input logic [9:0] w);
    tmds_raw = w;
    @(posedge clk_pixel);
    #1;
    if (mdl_on) begin
      hist.push_back(w);
      if (hist.size() > 2) model_step(hist.pop_front());
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] rot, tk, w;
    int n;
    bit exp_tv;
    repeat (2) @(posedge clk_pixel);
    #3;
    check_idle("rst");
    reset = 1'b0;
    tk  = tok_tab[0];
    rot = {tk[6:0], tk[9:7]};
    n = 0;
    while (!locked && n < 300) begin drive(rot); n++; end
    check("lock3", locked, 1);
    check("slip3", slip_offset, 3);
    repeat (LT) drive(10'h000);
    check("hold_lock", locked, 1);
    drive(10'h000);
    check("drop_lock", locked, 0);
    check("drop_slip", slip_offset, 3);
    n = 0;
    while (!locked && n < 300) begin drive(rot); n++; end
    check("relock3", locked, 1);
    drive(rot);
    #2 reset = 1'b1;
    #1 check_idle("arst");
    repeat (2) @(posedge clk_pixel);
    #3 reset = 1'b0;
    m_data = 0; m_ctrl = 0; de_known = 0;
    hist = '{10'h000, 10'h000};
    mdl_on = 1;
    for (int i = 1; i <= 32; i++) begin
      drive(10'h354);
      if (i == CLC) check("pre_lock", locked, 0);
      if (i == CLC + 3) check("lock0", locked, 1);
    end
    check("slip0", slip_offset, 0);
    check("ctrl00", ctrl, 0);
    de_known = 1;
    drive(10'h163); drive(10'h354); drive(10'h354);
    check("byte_a5", data, 8'hA5);
    check("de_a5", de, 1);
    check("is_ctrl_a5", is_ctrl, 0);
    drive(10'h2AB); drive(10'h0AB); drive(10'h354);
    check("ctrl11", ctrl, 2'b11);
    check("de_ctrl", de, 0);
    drive(10'h354);
    check("ctrl01", ctrl, 2'b01);
    drive(10'h13C); drive(10'h354); drive(10'h354);
`ifdef TMDS_DECODER_TERC4_EN
    exp_tv = 1;
`else
    exp_tv = 0;
`endif
    check("terc4_7_valid", terc4_valid, exp_tv);
    check("terc4_7", terc4, exp_tv ? 7 : 0);
    for (int i = 0; i < 400; i++) begin
      if (i % 6 == 5) w = tok_tab[$urandom_range(0, 3)];
      else if (i % 6 == 2) w = terc_tab[$urandom_range(0, 15)];
      else w = 10'($urandom_range(0, 1023));
      drive(w);
    end
    check("final_lock", locked, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
